// File: rtl/mux_bit_serializer.sv
// mux_bit_serializer: 16-bit parallel-to-serial stage in front of the 16:1 bit mux.
// Drives the mux selects (sel / isel) and data word (mux_data); returns mux_out as ser_bit.
// Optional build macro: MUX_SER_BACKTOBACK_EN lets a new word load on the last bit of the
// current word for a gapless stream; without it there is at least one IDLE cycle per word.

module mux_bit_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    output logic [3:0]  sel,
    output logic [3:0]  isel,
    output logic [15:0] mux_data,
    input  logic        mux_out,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_bit,
    output logic        ser_last,
    output logic        busy
);

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;

    // Select sweep endpoints and per-bit step (modulo 16) for the chosen bit order
    localparam logic [SW-1:0] FIRST = MSB_FIRST ? SW'(15) : SW'(0);
    localparam logic [SW-1:0] LAST  = MSB_FIRST ? SW'(0)  : SW'(15);
    localparam logic [SW-1:0] STEP  = MSB_FIRST ? SW'(15) : SW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_isel;
    logic [SW-1:0]   w_sel_nxt;
    logic [W-1:0]    r_data;
    logic [W-1:0]    w_data_nxt;
    logic            w_at_last;

    assign w_at_last = (r_sel == LAST);

    // State, select counter with its registered complement, and the held word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= FIRST;
            r_isel  <= ~FIRST;
            r_data  <= W'(0);
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_isel  <= ~w_sel_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state, select stepping, word capture and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_data;
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;
        busy        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_data_nxt  = load_data;
                    w_sel_nxt   = FIRST;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_last  = w_at_last;
`ifdef MUX_SER_BACKTOBACK_EN
                if (w_at_last) begin
                    load_ready = ser_ready;
                end
`endif
                if (ser_ready) begin
                    if (!w_at_last) begin
                        w_sel_nxt = r_sel + STEP;
                    end else begin
                        w_sel_nxt   = FIRST;
                        w_state_nxt = ST_IDLE;
`ifdef MUX_SER_BACKTOBACK_EN
                        // Chain straight into the next word when one is offered
                        if (load_valid) begin
                            w_data_nxt  = load_data;
                            w_state_nxt = ST_SHIFT;
                        end
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = FIRST;
            end
        endcase
    end

    assign sel      = r_sel;
    assign isel     = r_isel;
    assign mux_data = r_data;
    assign ser_bit  = mux_out;

endmodule

// File: tb/tb_mux_bit_serializer.sv
// tb_mux_bit_serializer: self-checking bench for both bit orders of mux_bit_serializer,
// with the 16:1 bit mux modelled as mux_data[sel].

module tb_mux_bit_serializer;

`ifdef MUX_SER_BACKTOBACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LSB-first instance
    logic        rst, load_valid, ser_ready;
    logic [15:0] load_data;
    logic        load_ready, ser_valid, ser_bit, ser_last, busy, mux_out;
    logic [3:0]  sel, isel;
    logic [15:0] mux_data;

    // MSB-first instance
    logic        m_rst, m_load_valid, m_ser_ready;
    logic [15:0] m_load_data;
    logic        m_load_ready, m_ser_valid, m_ser_bit, m_ser_last, m_busy, m_mux_out;
    logic [3:0]  m_sel, m_isel;
    logic [15:0] m_mux_data;

    assign mux_out   = mux_data[sel];
    assign m_mux_out = m_mux_data[m_sel];

    mux_bit_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .sel(sel), .isel(isel), .mux_data(mux_data),
        .mux_out(mux_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_bit(ser_bit), .ser_last(ser_last), .busy(busy)
    );

    mux_bit_serializer #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(m_rst), .load_valid(m_load_valid), .load_ready(m_load_ready),
        .load_data(m_load_data), .sel(m_sel), .isel(m_isel), .mux_data(m_mux_data),
        .mux_out(m_mux_out), .ser_valid(m_ser_valid), .ser_ready(m_ser_ready),
        .ser_bit(m_ser_bit), .ser_last(m_ser_last), .busy(m_busy)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; m_rst = 1'b1;
        load_valid = 1'b0; ser_ready = 1'b0; m_load_valid = 1'b0; m_ser_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %h exp 0", sel); end
        checks++; if (isel !== 4'hF) begin errors++; $display("FAIL reset_isel got %h exp f", isel); end
        checks++; if (mux_data !== 16'h0000) begin errors++; $display("FAIL reset_mux_data got %h exp 0000", mux_data); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid got %b exp 0", ser_valid); end
        checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL reset_ser_last got %b exp 0", ser_last); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (m_sel !== 4'hF) begin errors++; $display("FAIL reset_msb_sel got %h exp f", m_sel); end
        checks++; if (m_isel !== 4'h0) begin errors++; $display("FAIL reset_msb_isel got %h exp 0", m_isel); end
        rst = 1'b0; m_rst = 1'b0;
    endtask

    task automatic test_lsb_stream();
        bit exp_bits [16];
        exp_bits = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        @(negedge clk);
        load_valid = 1'b1; load_data = 16'hA5C3; ser_ready = 1'b1; #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL lsb_load_ready got %b exp 1", load_ready); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            load_valid = 1'b0; #1;
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid k=%0d got %b exp 1", k, ser_valid); end
            checks++; if (ser_bit !== exp_bits[k]) begin errors++; $display("FAIL lsb_bit k=%0d got %b exp %b", k, ser_bit, exp_bits[k]); end
            checks++; if (ser_last !== (k == 15)) begin errors++; $display("FAIL lsb_last k=%0d got %b exp %b", k, ser_last, (k == 15)); end
            checks++; if (sel !== 4'(k)) begin errors++; $display("FAIL lsb_sel k=%0d got %0d exp %0d", k, sel, k); end
            checks++; if (isel !== ~sel) begin errors++; $display("FAIL lsb_isel k=%0d got %h exp %h", k, isel, ~sel); end
        end
        @(negedge clk); #1;
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL lsb_end_valid got %b exp 0", ser_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL lsb_end_load_ready got %b exp 1", load_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsb_end_busy got %b exp 0", busy); end
        checks++; if (sel !== 4'h0) begin errors++; $display("FAIL lsb_end_sel got %h exp 0", sel); end
    endtask

    task automatic test_msb_first();
        logic exp_b;
        @(negedge clk);
        m_load_valid = 1'b1; m_load_data = 16'h8001; m_ser_ready = 1'b1; #1;
        checks++; if (m_load_ready !== 1'b1) begin errors++; $display("FAIL msb_load_ready got %b exp 1", m_load_ready); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            m_load_valid = 1'b0; #1;
            exp_b = (k == 0) || (k == 15);
            checks++; if (m_ser_valid !== 1'b1) begin errors++; $display("FAIL msb_valid k=%0d got %b exp 1", k, m_ser_valid); end
            checks++; if (m_ser_bit !== exp_b) begin errors++; $display("FAIL msb_bit k=%0d got %b exp %b", k, m_ser_bit, exp_b); end
            checks++; if (m_sel !== 4'(15 - k)) begin errors++; $display("FAIL msb_sel k=%0d got %0d exp %0d", k, m_sel, 15 - k); end
            checks++; if (m_isel !== ~m_sel) begin errors++; $display("FAIL msb_isel k=%0d got %h exp %h", k, m_isel, ~m_sel); end
            checks++; if (m_ser_last !== (k == 15)) begin errors++; $display("FAIL msb_last k=%0d got %b exp %b", k, m_ser_last, (k == 15)); end
        end
        @(negedge clk); #1;
        checks++; if (m_ser_valid !== 1'b0) begin errors++; $display("FAIL msb_end_valid got %b exp 0", m_ser_valid); end
        checks++; if (m_sel !== 4'hF) begin errors++; $display("FAIL msb_end_sel got %h exp f", m_sel); end
    endtask

    task automatic test_backpressure();
        bit          pat [4];
        logic [15:0] w;
        int          n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        w   = 16'h00F0;
        n   = 0;
        @(negedge clk);
        load_valid = 1'b1; load_data = w; ser_ready = 1'b0; #1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            load_valid = 1'b0; ser_ready = pat[cyc % 4]; #1;
            if (ser_valid !== 1'b1) break;
            checks++; if (n >= 16) begin errors++; $display("FAIL bp_extra_bit n=%0d exp at most 16", n); end
            else begin
                checks++; if (ser_bit !== w[n]) begin errors++; $display("FAIL bp_bit n=%0d got %b exp %b", n, ser_bit, w[n]); end
                checks++; if (sel !== 4'(n)) begin errors++; $display("FAIL bp_sel n=%0d got %0d exp %0d", n, sel, n); end
                checks++; if (ser_last !== (n == 15)) begin errors++; $display("FAIL bp_last n=%0d got %b exp %b", n, ser_last, (n == 15)); end
            end
            if (ser_ready) n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL bp_transfers got %0d exp 16", n); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b exp 0", ser_valid); end
        ser_ready = 1'b1;
    endtask

    task automatic test_mid_reset();
        int stray;
        stray = 0;
        @(negedge clk);
        load_valid = 1'b1; load_data = 16'hFFFF; ser_ready = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load_valid = 1'b0; #1;
            checks++; if (ser_valid !== 1'b1 || ser_bit !== 1'b1) begin errors++; $display("FAIL mr_bit k=%0d got v=%b b=%b exp v=1 b=1", k, ser_valid, ser_bit); end
        end
        @(negedge clk);
        rst = 1'b1; #1;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", ser_valid); end
        checks++; if (sel !== 4'h0 || isel !== 4'hF) begin errors++; $display("FAIL mr_sel got %h/%h exp 0/f", sel, isel); end
        checks++; if (mux_data !== 16'h0000) begin errors++; $display("FAIL mr_mux_data got %h exp 0000", mux_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", busy); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ser_valid !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mr_stray_bits got %0d exp 0", stray); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [2];
        int acc, nbits, gaps, idle_run, wi, bi;
        bit first_seen;
        words = '{16'h1234, 16'hFFFF};
        acc = 0; nbits = 0; gaps = 0; idle_run = 0; first_seen = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            load_valid = (acc < 2);
            load_data  = words[(acc < 2) ? acc : 1];
            ser_ready  = 1'b1; #1;
            if (ser_valid === 1'b1) begin
                if (first_seen) gaps += idle_run;
                idle_run   = 0;
                first_seen = 1'b1;
                checks++;
                if (nbits >= 32) begin errors++; $display("FAIL b2b_extra_bit n=%0d exp at most 32", nbits); end
                else begin
                    wi = nbits / 16; bi = nbits % 16;
                    if (ser_bit !== words[wi][bi]) begin errors++; $display("FAIL b2b_bit n=%0d got %b exp %b", nbits, ser_bit, words[wi][bi]); end
                    checks++; if (ser_last !== (bi == 15)) begin errors++; $display("FAIL b2b_last n=%0d got %b exp %b", nbits, ser_last, (bi == 15)); end
                    checks++; if (load_ready !== (B2B && bi == 15)) begin errors++; $display("FAIL b2b_load_ready n=%0d got %b exp %b", nbits, load_ready, (B2B && bi == 15)); end
                end
                nbits++;
            end else if (first_seen) begin
                idle_run++;
            end
            if (load_valid && load_ready) acc++;
        end
        load_valid = 1'b0;
        checks++; if (nbits != 32) begin errors++; $display("FAIL b2b_total_bits got %0d exp 32", nbits); end
        checks++; if (gaps != (B2B ? 0 : 1)) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", gaps, (B2B ? 0 : 1)); end
        checks++; if (acc != 2) begin errors++; $display("FAIL b2b_loads got %0d exp 2", acc); end
    endtask

    task automatic test_random();
        logic [15:0] cur;
        int          rem, pos;
        logic [3:0]  exp_sel;
        logic        exp_lr;
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cur = 16'h0000; rem = 0; pos = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 3) != 0);
            ser_ready  = ($urandom_range(0, 2) != 0);
            load_data  = 16'($urandom);
            #1;
            exp_sel = (rem > 0) ? 4'(pos) : 4'd0;
            exp_lr  = (rem == 0) ? 1'b1 : (B2B && rem == 1 && ser_ready);
            checks++; if (ser_valid !== (rem > 0) || busy !== (rem > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got v=%b busy=%b exp %b", cyc, ser_valid, busy, (rem > 0)); end
            checks++; if (load_ready !== exp_lr) begin errors++; $display("FAIL rnd_load_ready cyc=%0d got %b exp %b", cyc, load_ready, exp_lr); end
            checks++; if (mux_data !== cur) begin errors++; $display("FAIL rnd_mux_data cyc=%0d got %h exp %h", cyc, mux_data, cur); end
            checks++; if (sel !== exp_sel || isel !== ~exp_sel) begin errors++; $display("FAIL rnd_sel cyc=%0d got %h/%h exp %h/%h", cyc, sel, isel, exp_sel, ~exp_sel); end
            if (rem > 0) begin
                checks++; if (ser_bit !== cur[pos]) begin errors++; $display("FAIL rnd_bit cyc=%0d got %b exp %b", cyc, ser_bit, cur[pos]); end
                checks++; if (ser_last !== (rem == 1)) begin errors++; $display("FAIL rnd_last cyc=%0d got %b exp %b", cyc, ser_last, (rem == 1)); end
            end
            // Word-level model: bits remaining and position within the word
            if (rem == 0) begin
                if (load_valid) begin cur = load_data; rem = 16; pos = 0; end
            end else if (ser_ready) begin
                rem--; pos++;
                if (rem == 0 && B2B && load_valid) begin cur = load_data; rem = 16; pos = 0; end
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_valid = 1'b0; ser_ready = 1'b0; load_data = 16'h0000;
        m_rst = 1'b1; m_load_valid = 1'b0; m_ser_ready = 1'b0; m_load_data = 16'h0000;
        test_reset();
        test_lsb_stream();
        test_msb_first();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
